pazen_banked_mem_ctrl: RTL and testbench
========================================

# pazen_banked_mem_ctrl

Parametrised dual-port controller between the tracking datapath and a set of wide register-file banks. Each bank row packs several narrow lanes. The controller turns two narrow word-addressed ports (A, B) into bank, row and lane accesses. It returns read data through a registered 1-cycle path. It resolves write collisions on the single write port of each bank using lane-mask merging and a one-entry deferral buffer on port B.

## Interface
Parameters:
- DATA_W, 16, lane (port word) width
- LANES, 4, lanes per bank row; power of two; LB = $clog2(LANES)
- ROWS, 10, rows per bank; ROW_W = $clog2(ROWS)
- BANKS, 6, number of banks; DEPTH = BANKS*ROWS*LANES words
- ADDR_W, 8, port word-address width

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  synchronous, active-low reset
- a_valid, b_valid  in  1  request strobe, per port
- a_ready, b_ready  out  1  request accepted when valid && ready
- a_we, b_we  in  1  1 = write, 0 = read
- a_addr, b_addr  in  ADDR_W  word address
- a_wdata, b_wdata  in  DATA_W  write data
- a_rdata, b_rdata  out  DATA_W  registered read data
- a_rvalid, b_rvalid  out  1  read-data valid pulse
- a_err, b_err  out  1  registered pulse; accepted address >= DEPTH
- b_conflict  out  1  registered pulse; B write lost to A on the same lane
- bank_ra_sel, bank_rb_sel  out  BANKS  one-hot read select
- bank_ra_row, bank_rb_row  out  ROW_W  read row
- bank_ra_data, bank_rb_data  in  BANKS*LANES*DATA_W  asynchronous bank read data, bank i at slice i
- bank_we  out  BANKS  per-bank write enable
- bank_wrow  out  BANKS*ROW_W  per-bank write row
- bank_wdata  out  BANKS*LANES*DATA_W  per-bank wide write data; target lane carries data, other lanes are 0
- bank_wmask  out  BANKS*LANES  per-bank lane write mask

## Operation
- Decode:
  - lane = addr[LB-1:0]
  - row index r = addr >> LB
  - bank = r / ROWS, row = r - bank*ROWS
  - Implement as a constant-compare chain; no divider.
  - addr >= DEPTH is out of range.
- Reads:
  - Bank read select and row are driven combinationally from the accepted request.
  - The selected lane of bank_rX_data is registered into X_rdata, and X_rvalid pulses the next cycle.
  - An out-of-range read returns rdata = 0 with rvalid = 1 and err = 1.
- Writes are driven combinationally onto the bank write port in the accept cycle. An out-of-range write produces no bank_we and pulses err next cycle.
- Write arbitration for accepted A and B writes in the same cycle:
  - Different banks: both issue.
  - Same bank, same row, different lanes: one merged write; wmask is the OR of both masks.
  - Same bank, same row, same lane: A data written; B dropped; b_conflict pulses next cycle.
  - Same bank, different rows: A issues; B is latched into the hold buffer.
- Hold buffer (one entry; states EMPTY and HELD):
  - EMPTY to HELD on a deferral. HELD to EMPTY the cycle after, when the buffered write issues.
  - In HELD, b_ready = 0.
  - The buffered write has priority over an A write to the same bank; in that case a_ready = 0 for that cycle. A writes to other banks and all reads proceed.
- Reads never stall.

## Timing
- Reset values: a_ready = b_ready = 0 while reset is asserted, 1 after. rdata = 0, rvalid = 0, err = 0, b_conflict = 0, hold buffer EMPTY, bank_we = 0.
- Read latency: exactly 1 cycle from accept to rvalid. Back-to-back reads give one rvalid per cycle.
- Write-to-read on the same word: a read accepted the cycle after the write returns the new data (bank write at the clock edge).
- Reset asserted in HELD: the buffered write is discarded and never issued.
- Reset on the same edge as an accept: the request is ignored.

## Configuration
- PAZEN_MEM_FWD_EN defined: a read of a word being written in the same cycle (either port, or the held buffer entry) returns the write data, with A data taking precedence.
- PAZEN_MEM_FWD_EN undefined: such a read returns the old bank contents.
- Registered-output timing is identical in both builds.

## Structure
- Package pazen_mem_pkg holds:
  - Defaults for DATA_W, LANES, ROWS, BANKS.
  - The hold-buffer state enum (EMPTY, HELD).
  - A struct {bank, row, lane, oor} for the decoded address.
- One sub-module, pazen_addr_decode: the combinational address-to-{bank, row, lane, oor} decoder, instantiated once per port.

## Test plan
All scenarios use the default parameters.
1. A write addr 45, data 0xBEEF; then A read addr 45.
   - Write cycle: bank_we[1] = 1, row 1, mask 0010.
   - Read: a_rvalid one cycle after accept, a_rdata = 0xBEEF.
2. Same cycle: A write addr 8 data 0x1111, B write addr 9 data 0x2222.
   - Single bank 0 row 2 write, mask 0011, both readies stay 1.
   - Reads of 8 and 9 return 0x1111 and 0x2222.
3. Same cycle: A write addr 8, B write addr 12 data 0x3333.
   - A issues; b_ready = 0 next cycle.
   - Bank 0 row 3 written that cycle; read of 12 then returns 0x3333.
   - With PAZEN_MEM_FWD_EN, a read of 12 in the held cycle also returns 0x3333.
4. Same cycle: A write addr 8 data 0xAAAA, B write addr 8 data 0x5555.
   - Word 8 = 0xAAAA; b_conflict pulses once.
5. A read addr 250.
   - No bank access; next cycle a_rvalid = 1, a_rdata = 0, a_err = 1.
6. Reset asserted while the hold buffer is HELD.
   - No bank_we follows; all outputs take their reset values.
   - After release, both readies are 1.

Source files
------------

// File: rtl/pazen_mem_pkg.sv
// Shared types for the banked memory controller: parameter defaults, hold-buffer
// state and the decoded-address record.
package pazen_mem_pkg;

    localparam int unsigned DefDataW = 16;
    localparam int unsigned DefLanes = 4;
    localparam int unsigned DefRows  = 10;
    localparam int unsigned DefBanks = 6;
    localparam int unsigned DefAddrW = 8;

    // Field width for decoded indices; wide enough for any sane geometry.
    localparam int unsigned IdxW = 8;

    typedef enum logic [0:0] {
        StEmpty,
        StHeld
    } hold_state_e;

    typedef struct packed {
        logic [IdxW-1:0] bank;
        logic [IdxW-1:0] row;
        logic [IdxW-1:0] lane;
        logic            oor;
    } dec_addr_t;

    function automatic logic same_word(input dec_addr_t x, input dec_addr_t y);
        return (x.bank == y.bank) && (x.row == y.row) && (x.lane == y.lane);
    endfunction

endpackage

// File: rtl/pazen_addr_decode.sv
// Word address to {bank, row, lane, out-of-range} decoder; bank found by a
// constant-compare chain over row-index ranges, no divider.
module pazen_addr_decode
    import pazen_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned LANES  = DefLanes,
    parameter int unsigned ROWS   = DefRows,
    parameter int unsigned BANKS  = DefBanks
) (
    input  logic [ADDR_W-1:0] addr_i,
    output dec_addr_t         dec_o
);

    localparam int unsigned LB    = $clog2(LANES);
    localparam int unsigned DEPTH = BANKS * ROWS * LANES;

    logic [ADDR_W-1:0] ridx;

    always_comb begin
        ridx       = addr_i >> LB;
        dec_o      = '0;
        dec_o.lane = IdxW'(addr_i & ADDR_W'(LANES - 1));
        dec_o.oor  = 32'(addr_i) >= DEPTH;
        for (int unsigned b = 0; b < BANKS; b++) begin
            if (32'(ridx) >= b * ROWS && 32'(ridx) < (b + 1) * ROWS) begin
                dec_o.bank = IdxW'(b);
                dec_o.row  = IdxW'(32'(ridx) - b * ROWS);
            end
        end
    end

endmodule

// File: rtl/pazen_banked_mem_ctrl.sv
// Dual-port controller onto lane-packed register-file banks with write merging
// and a one-entry deferral buffer on port B. Optional read forwarding: PAZEN_MEM_FWD_EN.
module pazen_banked_mem_ctrl
    import pazen_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned LANES  = DefLanes,
    parameter int unsigned ROWS   = DefRows,
    parameter int unsigned BANKS  = DefBanks,
    parameter int unsigned ADDR_W = DefAddrW,
    localparam int unsigned ROW_W = $clog2(ROWS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            a_valid,
    input  logic                            b_valid,
    output logic                            a_ready,
    output logic                            b_ready,
    input  logic                            a_we,
    input  logic                            b_we,
    input  logic [ADDR_W-1:0]               a_addr,
    input  logic [ADDR_W-1:0]               b_addr,
    input  logic [DATA_W-1:0]               a_wdata,
    input  logic [DATA_W-1:0]               b_wdata,
    output logic [DATA_W-1:0]               a_rdata,
    output logic [DATA_W-1:0]               b_rdata,
    output logic                            a_rvalid,
    output logic                            b_rvalid,
    output logic                            a_err,
    output logic                            b_err,
    output logic                            b_conflict,
    output logic [BANKS-1:0]                bank_ra_sel,
    output logic [BANKS-1:0]                bank_rb_sel,
    output logic [ROW_W-1:0]                bank_ra_row,
    output logic [ROW_W-1:0]                bank_rb_row,
    input  logic [BANKS*LANES*DATA_W-1:0]   bank_ra_data,
    input  logic [BANKS*LANES*DATA_W-1:0]   bank_rb_data,
    output logic [BANKS-1:0]                bank_we,
    output logic [BANKS*ROW_W-1:0]          bank_wrow,
    output logic [BANKS*LANES*DATA_W-1:0]   bank_wdata,
    output logic [BANKS*LANES-1:0]          bank_wmask
);

    dec_addr_t   a_dec, b_dec, hold_dec_q, hold_dec_d;
    hold_state_e hold_q, hold_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic [DATA_W-1:0] a_rdata_q, b_rdata_q, a_word, b_word;
    logic a_rvalid_q, b_rvalid_q, a_err_q, b_err_q, b_conflict_q;
    logic hold_issue, a_acc, b_acc, a_wr, b_wr, a_rd, b_rd;
    logic same_bank, same_row, b_drop, b_defer, b_issue;
    logic              wr_en   [3];
    dec_addr_t         wr_dec  [3];
    logic [DATA_W-1:0] wr_data [3];

    pazen_addr_decode #(.ADDR_W(ADDR_W), .LANES(LANES), .ROWS(ROWS), .BANKS(BANKS)) u_dec_a (
        .addr_i (a_addr),
        .dec_o  (a_dec)
    );

    pazen_addr_decode #(.ADDR_W(ADDR_W), .LANES(LANES), .ROWS(ROWS), .BANKS(BANKS)) u_dec_b (
        .addr_i (b_addr),
        .dec_o  (b_dec)
    );

    always_comb begin
        hold_issue = (hold_q == StHeld) && reset && !hold_dec_q.oor;
        // A held B write owns its bank's write port; only A writes to that bank stall.
        a_ready = reset && !((hold_q == StHeld) && a_valid && a_we && !a_dec.oor &&
                             (a_dec.bank == hold_dec_q.bank));
        b_ready = reset && (hold_q == StEmpty);
        a_acc   = a_valid && a_ready;
        b_acc   = b_valid && b_ready;
        a_wr    = a_acc && a_we && !a_dec.oor;
        b_wr    = b_acc && b_we && !b_dec.oor;
        a_rd    = a_acc && !a_we;
        b_rd    = b_acc && !b_we;
        same_bank = a_wr && b_wr && (a_dec.bank == b_dec.bank);
        same_row  = same_bank && (a_dec.row == b_dec.row);
        b_drop    = same_row && (a_dec.lane == b_dec.lane);
        b_defer   = same_bank && !same_row;
        b_issue   = b_wr && !b_drop && !b_defer;
    end

    always_comb begin
        wr_en[0] = hold_issue; wr_dec[0] = hold_dec_q; wr_data[0] = hold_data_q;
        wr_en[1] = b_issue;    wr_dec[1] = b_dec;      wr_data[1] = b_wdata;
        wr_en[2] = a_wr;       wr_dec[2] = a_dec;      wr_data[2] = a_wdata;
        bank_we    = '0;
        bank_wrow  = '0;
        bank_wdata = '0;
        bank_wmask = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            for (int unsigned i = 0; i < BANKS; i++) begin
                if (wr_en[k] && (wr_dec[k].bank == IdxW'(i))) begin
                    bank_we[i] = 1'b1;
                    bank_wrow[i*ROW_W +: ROW_W] = wr_dec[k].row[ROW_W-1:0];
                    for (int unsigned l = 0; l < LANES; l++) begin
                        if (wr_dec[k].lane == IdxW'(l)) begin
                            bank_wmask[i*LANES+l] = 1'b1;
                            bank_wdata[(i*LANES+l)*DATA_W +: DATA_W] = wr_data[k];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        bank_ra_sel = '0;
        bank_rb_sel = '0;
        bank_ra_row = (a_rd && !a_dec.oor) ? a_dec.row[ROW_W-1:0] : '0;
        bank_rb_row = (b_rd && !b_dec.oor) ? b_dec.row[ROW_W-1:0] : '0;
        a_word = '0;
        b_word = '0;
        for (int unsigned i = 0; i < BANKS; i++) begin
            if (a_rd && !a_dec.oor && (a_dec.bank == IdxW'(i))) bank_ra_sel[i] = 1'b1;
            if (b_rd && !b_dec.oor && (b_dec.bank == IdxW'(i))) bank_rb_sel[i] = 1'b1;
            for (int unsigned l = 0; l < LANES; l++) begin
                if ((a_dec.bank == IdxW'(i)) && (a_dec.lane == IdxW'(l)))
                    a_word = bank_ra_data[(i*LANES+l)*DATA_W +: DATA_W];
                if ((b_dec.bank == IdxW'(i)) && (b_dec.lane == IdxW'(l)))
                    b_word = bank_rb_data[(i*LANES+l)*DATA_W +: DATA_W];
            end
        end
`ifdef PAZEN_MEM_FWD_EN
        // Later assignments win, so A data is applied last.
        if (hold_issue && same_word(hold_dec_q, a_dec)) a_word = hold_data_q;
        if (b_issue && same_word(b_dec, a_dec))         a_word = b_wdata;
        if (hold_issue && same_word(hold_dec_q, b_dec)) b_word = hold_data_q;
        if (a_wr && same_word(a_dec, b_dec))            b_word = a_wdata;
`endif
    end

    always_comb begin
        hold_d      = hold_q;
        hold_dec_d  = hold_dec_q;
        hold_data_d = hold_data_q;
        unique case (hold_q)
            StEmpty: begin
                if (b_defer) begin
                    hold_d      = StHeld;
                    hold_dec_d  = b_dec;
                    hold_data_d = b_wdata;
                end
            end
            StHeld:  hold_d = StEmpty;
            default: hold_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_q       <= StEmpty;
            hold_dec_q   <= '0;
            hold_data_q  <= '0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
            a_rvalid_q   <= 1'b0;
            b_rvalid_q   <= 1'b0;
            a_err_q      <= 1'b0;
            b_err_q      <= 1'b0;
            b_conflict_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_dec_q   <= hold_dec_d;
            hold_data_q  <= hold_data_d;
            a_rvalid_q   <= a_rd;
            b_rvalid_q   <= b_rd;
            a_err_q      <= a_acc && a_dec.oor;
            b_err_q      <= b_acc && b_dec.oor;
            b_conflict_q <= b_drop;
            if (a_rd) a_rdata_q <= a_dec.oor ? '0 : a_word;
            if (b_rd) b_rdata_q <= b_dec.oor ? '0 : b_word;
        end
    end

    assign a_rdata    = a_rdata_q;
    assign b_rdata    = b_rdata_q;
    assign a_rvalid   = a_rvalid_q;
    assign b_rvalid   = b_rvalid_q;
    assign a_err      = a_err_q;
    assign b_err      = b_err_q;
    assign b_conflict = b_conflict_q;

endmodule

// File: tb/tb_pazen_banked_mem_ctrl.sv
// Bench for pazen_banked_mem_ctrl: behavioural bank array, read scoreboard,
// vector table plus hand sequences for arbitration, hold buffer and reset.
module tb_pazen_banked_mem_ctrl;

    localparam int DW = 16, LN = 4, RW = 10, BK = 6, AW = 8, ROWW = 4, DEPTH = 240;

`ifdef PAZEN_MEM_FWD_EN
    localparam logic [15:0] Held12 = 16'h3333;
    localparam logic [15:0] Same77 = 16'h0505;
`else
    localparam logic [15:0] Held12 = 16'h0000;
    localparam logic [15:0] Same77 = 16'h0000;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic a_valid, b_valid, a_ready, b_ready, a_we, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata;
    logic a_rvalid, b_rvalid, a_err, b_err, b_conflict;
    logic [BK-1:0] bank_ra_sel, bank_rb_sel, bank_we;
    logic [ROWW-1:0] bank_ra_row, bank_rb_row;
    logic [BK*LN*DW-1:0] bank_ra_data, bank_rb_data, bank_wdata;
    logic [BK*ROWW-1:0] bank_wrow;
    logic [BK*LN-1:0] bank_wmask;

    pazen_banked_mem_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .a_valid      (a_valid),
        .b_valid      (b_valid),
        .a_ready      (a_ready),
        .b_ready      (b_ready),
        .a_we         (a_we),
        .b_we         (b_we),
        .a_addr       (a_addr),
        .b_addr       (b_addr),
        .a_wdata      (a_wdata),
        .b_wdata      (b_wdata),
        .a_rdata      (a_rdata),
        .b_rdata      (b_rdata),
        .a_rvalid     (a_rvalid),
        .b_rvalid     (b_rvalid),
        .a_err        (a_err),
        .b_err        (b_err),
        .b_conflict   (b_conflict),
        .bank_ra_sel  (bank_ra_sel),
        .bank_rb_sel  (bank_rb_sel),
        .bank_ra_row  (bank_ra_row),
        .bank_rb_row  (bank_rb_row),
        .bank_ra_data (bank_ra_data),
        .bank_rb_data (bank_rb_data),
        .bank_we      (bank_we),
        .bank_wrow    (bank_wrow),
        .bank_wdata   (bank_wdata),
        .bank_wmask   (bank_wmask)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural register-file banks: write at the clock edge, asynchronous read.
    logic [DW-1:0] mem [DEPTH] = '{default: '0};
    always @(posedge clk) begin
        for (int i = 0; i < BK; i++)
            if (bank_we[i])
                for (int l = 0; l < LN; l++)
                    if (bank_wmask[i*LN+l])
                        mem[(i*RW + int'(bank_wrow[i*ROWW +: ROWW]))*LN + l] <=
                            bank_wdata[(i*LN+l)*DW +: DW];
    end
    always_comb begin
        bank_ra_data = '0;
        bank_rb_data = '0;
        for (int i = 0; i < BK; i++)
            for (int l = 0; l < LN; l++) begin
                if (int'(bank_ra_row) < RW)
                    bank_ra_data[(i*LN+l)*DW +: DW] = mem[(i*RW + int'(bank_ra_row))*LN + l];
                if (int'(bank_rb_row) < RW)
                    bank_rb_data[(i*LN+l)*DW +: DW] = mem[(i*RW + int'(bank_rb_row))*LN + l];
            end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Read scoreboard: expectation pushed on accept, popped when rvalid is due.
    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            due;
    } exp_t;
    exp_t a_q[$];
    exp_t b_q[$];
    logic [DW-1:0] a_exp, b_exp;
    logic a_exp_err, b_exp_err;

    always @(negedge clk) begin
        exp_t e;
        if (a_q.size() > 0 && a_q[0].due == cyc) begin
            e = a_q.pop_front();
            check("a_rvalid", a_rvalid, 1);
            check("a_rdata", a_rdata, e.data);
            check("a_err", a_err, e.err);
        end else if (a_rvalid) begin
            check("a_rvalid spurious", a_rvalid, 0);
        end
        if (b_q.size() > 0 && b_q[0].due == cyc) begin
            e = b_q.pop_front();
            check("b_rvalid", b_rvalid, 1);
            check("b_rdata", b_rdata, e.data);
            check("b_err", b_err, e.err);
        end else if (b_rvalid) begin
            check("b_rvalid spurious", b_rvalid, 0);
        end
        if (a_valid && a_ready && !a_we) a_q.push_back('{a_exp, a_exp_err, cyc + 1});
        if (b_valid && b_ready && !b_we) b_q.push_back('{b_exp, b_exp_err, cyc + 1});
    end

    // For reads, d is the expected read data.
    task automatic drv_a(input logic v, input logic we, input logic [7:0] ad,
                         input logic [15:0] d, input logic e);
        a_valid = v; a_we = we; a_addr = ad; a_wdata = d; a_exp = d; a_exp_err = e;
    endtask
    task automatic drv_b(input logic v, input logic we, input logic [7:0] ad,
                         input logic [15:0] d, input logic e);
        b_valid = v; b_we = we; b_addr = ad; b_wdata = d; b_exp = d; b_exp_err = e;
    endtask
    task automatic idle();
        drv_a(0, 0, 8'd0, 16'h0, 0);
        drv_b(0, 0, 8'd0, 16'h0, 0);
    endtask
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic a_we; logic [7:0] a_addr; logic [15:0] a_d; logic a_e;
        logic b_we; logic [7:0] b_addr; logic [15:0] b_d; logic b_e;
    } vec_t;
    vec_t vecs [9];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 8'd0,   16'h0101, 1'b0, 1'b1, 8'd100, 16'h0202, 1'b0};
        vecs[1] = '{1'b1, 8'd239, 16'h0303, 1'b0, 1'b1, 8'd120, 16'h0404, 1'b0};
        vecs[2] = '{1'b0, 8'd100, 16'h0202, 1'b0, 1'b0, 8'd0,   16'h0101, 1'b0};
        vecs[3] = '{1'b0, 8'd120, 16'h0404, 1'b0, 1'b0, 8'd239, 16'h0303, 1'b0};
        vecs[4] = '{1'b0, 8'd240, 16'h0000, 1'b1, 1'b0, 8'd45,  16'hBEEF, 1'b0};
        vecs[5] = '{1'b1, 8'd77,  16'h0505, 1'b0, 1'b0, 8'd77,  Same77,   1'b0};
        vecs[6] = '{1'b0, 8'd77,  16'h0505, 1'b0, 1'b1, 8'd241, 16'h0F0F, 1'b0};
        vecs[7] = '{1'b0, 8'd9,   16'h2222, 1'b0, 1'b0, 8'd8,   16'hAAAA, 1'b0};
        vecs[8] = '{1'b0, 8'd20,  16'h7777, 1'b0, 1'b0, 8'd1,   16'h9999, 1'b0};

        // Reset: a read presented during reset must be ignored.
        idle();
        drv_a(1, 0, 8'd45, 16'h0, 0);
        repeat (2) begin
            @(negedge clk);
            check("rst a_ready", a_ready, 0);
            check("rst b_ready", b_ready, 0);
            check("rst bank_we", bank_we, 0);
        end
        next(); reset = 1'b1; idle();
        @(negedge clk);
        check("post-rst a_ready", a_ready, 1);
        check("post-rst b_ready", b_ready, 1);
        check("post-rst a_rdata", a_rdata, 0);
        check("post-rst a_err", a_err, 0);
        check("post-rst b_conflict", b_conflict, 0);

        // 1: write 45 then read it back.
        next(); drv_a(1, 1, 8'd45, 16'hBEEF, 0);
        @(negedge clk);
        check("s1 bank_we", bank_we, 6'b000010);
        check("s1 wrow", bank_wrow[7:4], 1);
        check("s1 wmask", bank_wmask[7:4], 4'b0010);
        check("s1 wdata", bank_wdata[(1*4+1)*16 +: 16], 16'hBEEF);
        next(); drv_a(1, 0, 8'd45, 16'hBEEF, 0);
        @(negedge clk);
        check("s1 ra_sel", bank_ra_sel, 6'b000010);
        check("s1 ra_row", bank_ra_row, 1);

        // 2: same row, different lanes merge.
        next(); drv_a(1, 1, 8'd8, 16'h1111, 0); drv_b(1, 1, 8'd9, 16'h2222, 0);
        @(negedge clk);
        check("s2 bank_we", bank_we, 6'b000001);
        check("s2 wrow", bank_wrow[3:0], 2);
        check("s2 wmask", bank_wmask[3:0], 4'b0011);
        check("s2 wdata", bank_wdata[31:0], 32'h2222_1111);
        check("s2 a_ready", a_ready, 1);
        check("s2 b_ready", b_ready, 1);
        next(); drv_a(1, 0, 8'd8, 16'h1111, 0); drv_b(1, 0, 8'd9, 16'h2222, 0);

        // 3: same bank, different rows defers B.
        next(); drv_a(1, 1, 8'd8, 16'h1111, 0); drv_b(1, 1, 8'd12, 16'h3333, 0);
        @(negedge clk);
        check("s3 a bank_we", bank_we, 6'b000001);
        check("s3 a wrow", bank_wrow[3:0], 2);
        check("s3 a wmask", bank_wmask[3:0], 4'b0001);
        next(); drv_a(1, 0, 8'd12, Held12, 0); drv_b(0, 0, 8'd0, 16'h0, 0);
        @(negedge clk);
        check("s3 held b_ready", b_ready, 0);
        check("s3 held a_ready", a_ready, 1);
        check("s3 held bank_we", bank_we, 6'b000001);
        check("s3 held wrow", bank_wrow[3:0], 3);
        check("s3 held wdata", bank_wdata[15:0], 16'h3333);
        next(); drv_a(1, 0, 8'd12, 16'h3333, 0);
        @(negedge clk);
        check("s3 after b_ready", b_ready, 1);

        // 3b: held write blocks an A write to its bank for one cycle.
        next(); drv_a(1, 1, 8'd16, 16'h6666, 0); drv_b(1, 1, 8'd20, 16'h7777, 0);
        @(negedge clk);
        check("s3b a wrow", bank_wrow[3:0], 4);
        next(); drv_a(1, 1, 8'd1, 16'h9999, 0); drv_b(0, 0, 8'd0, 16'h0, 0);
        @(negedge clk);
        check("s3b held a_ready", a_ready, 0);
        check("s3b held wrow", bank_wrow[3:0], 5);
        check("s3b held wdata", bank_wdata[15:0], 16'h7777);
        next();
        @(negedge clk);
        check("s3b retry a_ready", a_ready, 1);
        check("s3b retry wrow", bank_wrow[3:0], 0);
        check("s3b retry wmask", bank_wmask[3:0], 4'b0010);

        // 4: same lane, A wins, B reported.
        next(); drv_a(1, 1, 8'd8, 16'hAAAA, 0); drv_b(1, 1, 8'd8, 16'h5555, 0);
        @(negedge clk);
        check("s4 wmask", bank_wmask[3:0], 4'b0001);
        check("s4 wdata", bank_wdata[15:0], 16'hAAAA);
        check("s4 conflict early", b_conflict, 0);
        next(); idle();
        @(negedge clk);
        check("s4 conflict", b_conflict, 1);
        next();
        @(negedge clk);
        check("s4 conflict once", b_conflict, 0);

        // 5: out-of-range read.
        next(); drv_a(1, 0, 8'd250, 16'h0, 1);
        @(negedge clk);
        check("s5 ra_sel", bank_ra_sel, 0);
        check("s5 bank_we", bank_we, 0);
        next(); idle();

        for (int i = 0; i < 9; i++) begin
            next();
            drv_a(1, vecs[i].a_we, vecs[i].a_addr, vecs[i].a_d, vecs[i].a_e);
            drv_b(1, vecs[i].b_we, vecs[i].b_addr, vecs[i].b_d, vecs[i].b_e);
        end
        next(); idle();
        @(negedge clk);
        check("vec oor write b_err", b_err, 0);

        // 6: reset while HELD discards the buffered write.
        next(); drv_a(1, 1, 8'd8, 16'h1234, 0); drv_b(1, 1, 8'd12, 16'h4444, 0);
        next(); reset = 1'b0; drv_a(1, 1, 8'd0, 16'h5678, 0); drv_b(0, 0, 8'd0, 16'h0, 0);
        @(negedge clk);
        check("s6 rst bank_we", bank_we, 0);
        check("s6 rst a_ready", a_ready, 0);
        check("s6 rst b_ready", b_ready, 0);
        next(); reset = 1'b1; idle();
        @(negedge clk);
        check("s6 bank_we", bank_we, 0);
        check("s6 a_ready", a_ready, 1);
        check("s6 b_ready", b_ready, 1);
        check("s6 a_rdata", a_rdata, 0);
        check("s6 b_rdata", b_rdata, 0);
        check("s6 a_rvalid", a_rvalid, 0);
        next(); drv_a(1, 0, 8'd12, 16'h3333, 0); drv_b(1, 0, 8'd8, 16'h1234, 0);
        next(); drv_a(1, 0, 8'd0, 16'h0101, 0); drv_b(0, 0, 8'd0, 16'h0, 0);
        next(); idle();
        next(); next();
        @(negedge clk);

        check("a scoreboard drained", a_q.size(), 0);
        check("b scoreboard drained", b_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
